// File: rtl/gate_sweep_checker.sv
// Exhaustive sweep checker for a small combinational gate. On start it walks
// every input pattern, holds each one for SETTLE+1 cycles and compares the
// gate output against a golden reduction op. It reports the mismatch count and
// the first failing pattern.
module gate_sweep_checker #(
    parameter int unsigned N_IN   = 2,
    parameter int unsigned SETTLE = 1,
    parameter int unsigned ERR_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        op_sel,
    output logic [N_IN-1:0]   stim,
    input  logic              dut_y,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              op_err,
    output logic [ERR_W-1:0]  err_cnt,
    output logic              fail_valid,
    output logic [N_IN-1:0]   fail_vec
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFin
    } state_e;

    localparam logic [3:0] SettleLast = 4'(SETTLE);

    state_e             r_state;
    state_e             w_state_next;
    logic [2:0]         r_op;
    logic [2:0]         w_op_next;
    logic [N_IN-1:0]    r_stim;
    logic [N_IN-1:0]    w_stim_next;
    logic [3:0]         r_hold;
    logic [3:0]         w_hold_next;
    logic [ERR_W-1:0]   r_err_cnt;
    logic [ERR_W-1:0]   w_err_cnt_next;
    logic               r_fail_valid;
    logic               w_fail_valid_next;
    logic [N_IN-1:0]    r_fail_vec;
    logic [N_IN-1:0]    w_fail_vec_next;
    logic               r_pass;
    logic               w_pass_next;
    logic               r_op_err;
    logic               w_op_err_next;

    logic               w_golden;
    logic               w_mismatch;
    logic               w_sample;

    // Golden value: the latched op reduced over every stim bit.
    always_comb begin
        w_golden = 1'b0;
        case (r_op)
            3'd0:    w_golden = &r_stim;
            3'd1:    w_golden = |r_stim;
            3'd2:    w_golden = ~&r_stim;
            3'd3:    w_golden = ~|r_stim;
            3'd4:    w_golden = ^r_stim;
            3'd5:    w_golden = ~^r_stim;
            default: w_golden = 1'b0;
        endcase
    end

    // Anything other than an exact match (including X/Z) counts as a mismatch.
    always_comb begin
        w_mismatch = 1'b1;
        if (dut_y == w_golden) begin
            w_mismatch = 1'b0;
        end
    end

    assign w_sample = (r_hold == SettleLast);

    // Next-state and datapath update for the sweep FSM.
    always_comb begin
        w_state_next      = r_state;
        w_op_next         = r_op;
        w_stim_next       = r_stim;
        w_hold_next       = r_hold;
        w_err_cnt_next    = r_err_cnt;
        w_fail_valid_next = r_fail_valid;
        w_fail_vec_next   = r_fail_vec;
        w_pass_next       = r_pass;
        w_op_err_next     = r_op_err;

        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_op_next         = op_sel;
                    w_stim_next       = '0;
                    w_hold_next       = '0;
                    w_err_cnt_next    = '0;
                    w_fail_valid_next = 1'b0;
                    w_fail_vec_next   = '0;
                    w_pass_next       = 1'b0;
                    if (op_sel <= 3'd5) begin
                        w_op_err_next = 1'b0;
                        w_state_next  = StRun;
                    end else begin
                        // Reserved op: report and finish without sweeping.
                        w_op_err_next = 1'b1;
                        w_state_next  = StFin;
                    end
                end
            end
            StRun: begin
                if (w_sample) begin
                    if (w_mismatch) begin
                        if (!(&r_err_cnt)) begin
                            w_err_cnt_next = r_err_cnt + 1'b1;
                        end
                        if (!r_fail_valid) begin
                            w_fail_valid_next = 1'b1;
                            w_fail_vec_next   = r_stim;
                        end
                    end
                    // Wrap of the pattern counter back to zero ends the sweep.
                    w_stim_next = r_stim + 1'b1;
                    w_hold_next = '0;
                    if (&r_stim) begin
                        w_state_next = StFin;
                        w_pass_next  = !w_mismatch && (r_err_cnt == '0);
                    end
                end else begin
                    w_hold_next = r_hold + 4'd1;
                end
            end
            StFin: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // State and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_op         <= '0;
            r_stim       <= '0;
            r_hold       <= '0;
            r_err_cnt    <= '0;
            r_fail_valid <= 1'b0;
            r_fail_vec   <= '0;
            r_pass       <= 1'b0;
            r_op_err     <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_op         <= w_op_next;
            r_stim       <= w_stim_next;
            r_hold       <= w_hold_next;
            r_err_cnt    <= w_err_cnt_next;
            r_fail_valid <= w_fail_valid_next;
            r_fail_vec   <= w_fail_vec_next;
            r_pass       <= w_pass_next;
            r_op_err     <= w_op_err_next;
        end
    end

    assign stim       = r_stim;
    assign busy       = (r_state == StRun);
    assign done       = (r_state == StFin);
    assign pass       = r_pass;
    assign op_err     = r_op_err;
    assign err_cnt    = r_err_cnt;
    assign fail_valid = r_fail_valid;
    assign fail_vec   = r_fail_vec;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Directed bench for gate_sweep_checker: three instances cover the default
// configuration, a narrow saturating counter, and the zero-settle case.
module tb_gate_sweep_checker;

    logic clk;
    logic rst_n;

    // Instance A: N_IN=2, SETTLE=1, ERR_W=8
    logic       start_a;
    logic [2:0] op_a;
    logic [1:0] stim_a;
    logic       y_a;
    logic       busy_a, done_a, pass_a, operr_a, fv_a;
    logic [7:0] err_a;
    logic [1:0] fvec_a;
    int         model_a;

    // Instance B: N_IN=4, SETTLE=1, ERR_W=2
    logic       start_b;
    logic [2:0] op_b;
    logic [3:0] stim_b;
    logic       y_b;
    logic       busy_b, done_b, pass_b, operr_b, fv_b;
    logic [1:0] err_b;
    logic [3:0] fvec_b;

    // Instance C: N_IN=3, SETTLE=0, ERR_W=8
    logic       start_c;
    logic [2:0] op_c;
    logic [2:0] stim_c;
    logic       y_c;
    logic       busy_c, done_c, pass_c, operr_c, fv_c;
    logic [7:0] err_c;
    logic [2:0] fvec_c;

    int vectors;
    int miscompares;

    gate_sweep_checker #(.N_IN(2), .SETTLE(1), .ERR_W(8)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .op_sel(op_a), .stim(stim_a),
        .dut_y(y_a), .busy(busy_a), .done(done_a), .pass(pass_a), .op_err(operr_a),
        .err_cnt(err_a), .fail_valid(fv_a), .fail_vec(fvec_a)
    );

    gate_sweep_checker #(.N_IN(4), .SETTLE(1), .ERR_W(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .op_sel(op_b), .stim(stim_b),
        .dut_y(y_b), .busy(busy_b), .done(done_b), .pass(pass_b), .op_err(operr_b),
        .err_cnt(err_b), .fail_valid(fv_b), .fail_vec(fvec_b)
    );

    gate_sweep_checker #(.N_IN(3), .SETTLE(0), .ERR_W(8)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .op_sel(op_c), .stim(stim_c),
        .dut_y(y_c), .busy(busy_c), .done(done_c), .pass(pass_c), .op_err(operr_c),
        .err_cnt(err_c), .fail_valid(fv_c), .fail_vec(fvec_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gate models: 0 NOR, 1 stuck-0, 2 stuck-1, 3 OR, 4 XNOR
    always_comb begin
        case (model_a)
            0:       y_a = ~|stim_a;
            1:       y_a = 1'b0;
            2:       y_a = 1'b1;
            3:       y_a = |stim_a;
            4:       y_a = ~^stim_a;
            default: y_a = 1'b0;
        endcase
    end
    assign y_b = ~&stim_b;  // always the inverse of the AND golden
    assign y_c = ^stim_c;   // ideal XOR

    // One sweep on A; optionally pulses start with op 0 at busy cycle disturb_at.
    task automatic run_a(input logic [2:0] op, input int disturb_at,
                         output int cycles, output bit stim_ok, output bit early_done);
        stim_ok    = 1'b1;
        early_done = 1'b0;
        cycles     = 0;
        @(posedge clk); #1;
        op_a    = op;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        while (busy_a && cycles < 100) begin
            if (stim_a !== 2'(cycles / 2)) stim_ok = 1'b0;
            if (done_a) early_done = 1'b1;
            if (cycles == disturb_at) begin
                start_a = 1'b1;
                op_a    = 3'd0;
            end else begin
                start_a = 1'b0;
            end
            cycles++;
            @(posedge clk); #1;
        end
        start_a = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        op_a = 3'd0; op_b = 3'd0; op_c = 3'd0;
        model_a = 0;
        #12;
        vectors++;
        if ({busy_a, done_a, pass_a, operr_a, fv_a, err_a, stim_a, fvec_a} !== 15'd0) begin
            $display("FAIL reset_a: got %h expected 0",
                     {busy_a, done_a, pass_a, operr_a, fv_a, err_a, stim_a, fvec_a});
            miscompares++;
        end
        vectors++;
        if ({busy_b, done_b, pass_b, err_b, stim_b, busy_c, done_c, stim_c} !== 16'd0) begin
            $display("FAIL reset_bc: got %h expected 0",
                     {busy_b, done_b, pass_b, err_b, stim_b, busy_c, done_c, stim_c});
            miscompares++;
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
    endtask

    task automatic test_ideal_nor();
        int cyc; bit ok; bit ed;
        model_a = 0;
        run_a(3'd3, -1, cyc, ok, ed);
        vectors++;
        if (cyc != 8) begin
            $display("FAIL nor_busy_len: got %0d expected 8", cyc); miscompares++;
        end
        vectors++;
        if (!ok || ed) begin
            $display("FAIL nor_stim_seq: stim_ok %0d early_done %0d expected 1 0", ok, ed);
            miscompares++;
        end
        vectors++;
        if ({done_a, pass_a, fv_a, err_a, stim_a} !== {3'b110, 8'd0, 2'b00}) begin
            $display("FAIL nor_result: got done %0d pass %0d fv %0d err %0d stim %0d expected 1 1 0 0 0",
                     done_a, pass_a, fv_a, err_a, stim_a);
            miscompares++;
        end
        @(posedge clk); #1;
        vectors++;
        if (done_a !== 1'b0 || pass_a !== 1'b1) begin
            $display("FAIL nor_done_pulse: got done %0d pass %0d expected 0 1", done_a, pass_a);
            miscompares++;
        end
    endtask

    task automatic test_stuck();
        int cyc; bit ok; bit ed;
        model_a = 1;
        run_a(3'd3, -1, cyc, ok, ed);
        vectors++;
        if ({err_a, fv_a, fvec_a, pass_a} !== {8'd1, 1'b1, 2'b00, 1'b0}) begin
            $display("FAIL stuck0_nor: got err %0d fv %0d fvec %b pass %0d expected 1 1 00 0",
                     err_a, fv_a, fvec_a, pass_a);
            miscompares++;
        end
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({err_a, fv_a, fvec_a} !== {8'd1, 1'b1, 2'b00}) begin
            $display("FAIL result_hold: got err %0d fv %0d fvec %b expected 1 1 00",
                     err_a, fv_a, fvec_a);
            miscompares++;
        end
        model_a = 2;
        run_a(3'd0, -1, cyc, ok, ed);
        vectors++;
        if ({err_a, fvec_a, pass_a} !== {8'd3, 2'b00, 1'b0}) begin
            $display("FAIL stuck1_and: got err %0d fvec %b pass %0d expected 3 00 0",
                     err_a, fvec_a, pass_a);
            miscompares++;
        end
        // Stuck-0 against OR fails on 01,10,11: first failure must stay 01.
        model_a = 1;
        run_a(3'd1, -1, cyc, ok, ed);
        vectors++;
        if ({err_a, fvec_a, fv_a} !== {8'd3, 2'b01, 1'b1}) begin
            $display("FAIL first_fail_kept: got err %0d fvec %b fv %0d expected 3 01 1",
                     err_a, fvec_a, fv_a);
            miscompares++;
        end
    endtask

    task automatic test_saturate();
        int cyc; bit ok; bit ed; int n;
        model_a = 3;
        run_a(3'd3, -1, cyc, ok, ed);
        vectors++;
        if ({err_a, fvec_a, pass_a} !== {8'd4, 2'b00, 1'b0}) begin
            $display("FAIL all_wrong: got err %0d fvec %b pass %0d expected 4 00 0",
                     err_a, fvec_a, pass_a);
            miscompares++;
        end
        @(posedge clk); #1;
        op_b = 3'd0;
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        n = 0;
        while (busy_b && n < 200) begin
            n++;
            @(posedge clk); #1;
        end
        vectors++;
        if (n != 32) begin
            $display("FAIL sat_busy_len: got %0d expected 32", n); miscompares++;
        end
        vectors++;
        if ({err_b, fvec_b, fv_b, pass_b, done_b} !== {2'd3, 4'b0000, 3'b101}) begin
            $display("FAIL sat_result: got err %0d fvec %b fv %0d pass %0d done %0d expected 3 0000 1 0 1",
                     err_b, fvec_b, fv_b, pass_b, done_b);
            miscompares++;
        end
    endtask

    task automatic test_reserved();
        int cyc; bit ok; bit ed;
        @(posedge clk); #1;
        op_a = 3'd6;
        start_a = 1'b1;
        @(posedge clk); #1;
        // In FIN now: this start must be ignored.
        op_a = 3'd3;
        vectors++;
        if ({done_a, operr_a, pass_a, busy_a, err_a} !== {4'b1100, 8'd0}) begin
            $display("FAIL rsvd_op: got done %0d op_err %0d pass %0d busy %0d err %0d expected 1 1 0 0 0",
                     done_a, operr_a, pass_a, busy_a, err_a);
            miscompares++;
        end
        @(posedge clk); #1;
        start_a = 1'b0;
        vectors++;
        if ({busy_a, done_a, operr_a} !== 3'b001) begin
            $display("FAIL start_in_fin: got busy %0d done %0d op_err %0d expected 0 0 1",
                     busy_a, done_a, operr_a);
            miscompares++;
        end
        model_a = 4;
        run_a(3'd5, -1, cyc, ok, ed);
        vectors++;
        if ({operr_a, pass_a, err_a} !== {2'b01, 8'd0} || cyc != 8) begin
            $display("FAIL xnor_after_rsvd: got op_err %0d pass %0d err %0d cycles %0d expected 0 1 0 8",
                     operr_a, pass_a, err_a, cyc);
            miscompares++;
        end
    endtask

    task automatic test_back_to_back();
        int cyc; bit ok; bit ed; int n;
        model_a = 0;
        run_a(3'd3, -1, cyc, ok, ed);
        @(posedge clk); #1;
        // First IDLE cycle after FIN: start here must be taken.
        op_a = 3'd3;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        vectors++;
        if ({busy_a, pass_a, stim_a, err_a} !== {2'b10, 2'b00, 8'd0}) begin
            $display("FAIL b2b_start: got busy %0d pass %0d stim %0d err %0d expected 1 0 0 0",
                     busy_a, pass_a, stim_a, err_a);
            miscompares++;
        end
        n = 0;
        while (busy_a && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        vectors++;
        if (n != 8 || pass_a !== 1'b1 || done_a !== 1'b1) begin
            $display("FAIL b2b_sweep: got cycles %0d pass %0d done %0d expected 8 1 1",
                     n, pass_a, done_a);
            miscompares++;
        end
    endtask

    task automatic test_midsweep();
        int cyc; bit ok; bit ed;
        model_a = 0;
        run_a(3'd3, 3, cyc, ok, ed);
        vectors++;
        if (cyc != 8 || !ok || pass_a !== 1'b1 || err_a !== 8'd0) begin
            $display("FAIL op_change_ignored: got cycles %0d stim_ok %0d pass %0d err %0d expected 8 1 1 0",
                     cyc, ok, pass_a, err_a);
            miscompares++;
        end
    endtask

    task automatic test_reset_midsweep();
        int cyc; bit ok; bit ed; int n; bit saw_done;
        model_a = 1;
        @(posedge clk); #1;
        op_a = 3'd3;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        n = 0;
        while (n < 5) begin
            n++;
            @(posedge clk); #1;
        end
        vectors++;
        if (busy_a !== 1'b1 || err_a !== 8'd1) begin
            $display("FAIL pre_reset: got busy %0d err %0d expected 1 1", busy_a, err_a);
            miscompares++;
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy_a, done_a, pass_a, operr_a, fv_a, err_a, stim_a, fvec_a} !== 15'd0) begin
            $display("FAIL async_reset: got %h expected 0",
                     {busy_a, done_a, pass_a, operr_a, fv_a, err_a, stim_a, fvec_a});
            miscompares++;
        end
        saw_done = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            if (done_a) saw_done = 1'b1;
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            if (done_a) saw_done = 1'b1;
        end
        vectors++;
        if (saw_done) begin
            $display("FAIL reset_no_done: got done pulse expected none"); miscompares++;
        end
        model_a = 0;
        run_a(3'd3, -1, cyc, ok, ed);
        vectors++;
        if (cyc != 8 || !ok || pass_a !== 1'b1 || err_a !== 8'd0) begin
            $display("FAIL post_reset_sweep: got cycles %0d stim_ok %0d pass %0d err %0d expected 8 1 1 0",
                     cyc, ok, pass_a, err_a);
            miscompares++;
        end
    endtask

    task automatic test_zero_settle();
        int n; bit ok;
        @(posedge clk); #1;
        op_c = 3'd4;
        start_c = 1'b1;
        @(posedge clk); #1;
        start_c = 1'b0;
        n = 0;
        ok = 1'b1;
        while (busy_c && n < 100) begin
            if (stim_c !== 3'(n)) ok = 1'b0;
            n++;
            @(posedge clk); #1;
        end
        vectors++;
        if (n != 8 || !ok) begin
            $display("FAIL fast_sweep: got cycles %0d stim_ok %0d expected 8 1", n, ok);
            miscompares++;
        end
        vectors++;
        if ({pass_c, done_c, err_c} !== {2'b11, 8'd0}) begin
            $display("FAIL fast_result: got pass %0d done %0d err %0d expected 1 1 0",
                     pass_c, done_c, err_c);
            miscompares++;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_ideal_nor();
        test_stuck();
        test_saturate();
        test_reserved();
        test_back_to_back();
        test_midsweep();
        test_reset_midsweep();
        test_zero_settle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
